// File: rtl/cpu0_pkg.sv
// Shared cpu0 definitions: operand width codes, memory map constants and the
// state encoding used by the memory bus arbiter.
package cpu0_pkg;

    localparam logic [1:0] INT32 = 2'b11;
    localparam logic [1:0] INT24 = 2'b10;
    localparam logic [1:0] INT16 = 2'b01;
    localparam logic [1:0] BYTE  = 2'b00;

    localparam logic [31:0] MEMSIZE = 32'h0000_7000;
    localparam logic [31:0] IOADDR  = 32'h0000_7000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not own
// the bus last time wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner,
    output logic any_req
);

    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 && req1) ? ~last_grant : req1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between the cpu0 path (port 0) and a DMA/IO
// engine (port 1) with req/ack handshakes and a fixed-length access window.
module mem_bus_arbiter
    import cpu0_pkg::*;
#(
    parameter logic [31:0] MEMSIZE    = cpu0_pkg::MEMSIZE,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        rw0,
    input  logic [1:0]  size0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        rw1,
    input  logic [1:0]  size1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] mar,
    output logic [31:0] mdr,
    input  logic [31:0] dbus_in,
    output logic        grant,
    output logic        busy
);

    localparam int          CNT_W    = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_CYCLES - 1);
    localparam logic [31:0] MAX_ADDR = MEMSIZE - 32'd4;

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_en_q, m_en_d, m_rw_q, m_rw_d;
    logic [1:0]       m_size_q, m_size_d;
    logic [31:0]      mar_q, mar_d, mdr_q, mdr_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic [31:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic             grant_q, grant_d, busy_q, busy_d;

    logic             winner, any_req;
    logic [31:0]      sel_addr;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign sel_addr = winner ? addr1 : addr0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_en_d   = m_en_q;
        m_rw_d   = m_rw_q;
        m_size_d = m_size_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant_d  = grant_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d  = winner;
                    mar_d    = sel_addr;
                    mdr_d    = winner ? wdata1 : wdata0;
                    m_rw_d   = winner ? rw1 : rw0;
                    m_size_d = winner ? size1 : size0;
                    // Out-of-range requests complete at once without touching memory.
                    if (sel_addr > MAX_ADDR) begin
                        state_d = DONE;
                        if (winner) begin
                            ack1_d   = 1'b1;
                            err1_d   = 1'b1;
                            rdata1_d = '0;
                        end else begin
                            ack0_d   = 1'b1;
                            err0_d   = 1'b1;
                            rdata0_d = '0;
                        end
                    end else begin
                        m_en_d  = 1'b1;
                        cnt_d   = CNT_INIT;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    m_en_d  = 1'b0;
                    state_d = DONE;
                    if (grant_q) begin
                        ack1_d = 1'b1;
                        err1_d = 1'b0;
                        if (m_rw_q) rdata1_d = dbus_in;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = 1'b0;
                        if (m_rw_q) rdata0_d = dbus_in;
                    end
                end
            end
            DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_en_q   <= 1'b0;
            m_rw_q   <= 1'b1;
            m_size_q <= INT32;
            mar_q    <= '0;
            mdr_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            grant_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_en_q   <= m_en_d;
            m_rw_q   <= m_rw_d;
            m_size_q <= m_size_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign m_en   = m_en_q;
    assign m_rw   = m_rw_q;
    assign m_size = m_size_q;
    assign mar    = mar_q;
    assign mdr    = mdr_q;
    assign ack0   = ack0_q;
    assign err0   = err0_q;
    assign rdata0 = rdata0_q;
    assign ack1   = ack1_q;
    assign err1   = err1_q;
    assign rdata1 = rdata1_q;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule
